// File: rtl/seq_alu.sv
// Registered add/sub/abs-difference ALU with a multi-cycle signed shift-add multiply.
// Results and flags hold until the next operation completes; done pulses once per operation.
module seq_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ABS = 2'b01,
    OP_SUB = 2'b10,
    OP_MUL = 2'b11
  } op_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   mag;
  logic               add_ov;
  logic               sub_ov;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ov;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     prod_hi;
  logic               mul_ov;

  // Single-cycle operations, evaluated on the live operands at the accepting edge.
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    add_ov  = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
    sub_ov  = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
    mag     = diff[MSB] ? -diff : diff;
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = add_ov;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = sub_ov;
      end
      OP_ABS: begin
        alu_res = mag;
        alu_ov  = sub_ov | (diff == MIN_VAL);
      end
      default: begin
        alu_res = '0;
        alu_ov  = 1'b0;
      end
    endcase
  end

  // Two's complement shift-add: the multiplier's sign bit carries weight -2^(W-1),
  // so the final iteration subtracts the shifted multiplicand instead of adding it.
  always_comb begin
    addend   = mplier[0] ? mcand : '0;
    acc_next = (cnt == LAST) ? (acc - addend) : (acc + addend);
    prod_hi  = acc_next[2*WIDTH-1:WIDTH-1];
    mul_ov   = !((&prod_hi) || !(|prod_hi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{A[MSB]}}, A};
              mplier <= B;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else begin
              result   <= alu_res;
              overflow <= alu_ov;
              zero     <= (alu_res == '0);
              done     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            result   <= acc_next[WIDTH-1:0];
            overflow <= mul_ov;
            zero     <= (acc_next[WIDTH-1:0] == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a WIDTH=4 and a WIDTH=8 instance checked every cycle against an
// arithmetic protocol model, plus directed vectors with literal expected values.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic [1:0] op4, op8;
  logic       busy4, done4, ov4, z4;
  logic       busy8, done8, ov8, z8;
  logic [3:0] res4;
  logic [7:0] res8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .op(op4),
    .busy(busy4), .done(done4), .result(res4), .overflow(ov4), .zero(z4)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .op(op8),
    .busy(busy8), .done(done8), .result(res8), .overflow(ov8), .zero(z8)
  );

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on signed integers; returns {overflow, result}.
  function automatic logic [32:0] model_op(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input int unsigned w);
    longint sa, sb, r, dv, mx, mn, mask;
    logic ov;
    mask = (longint'(1) << w) - 1;
    mx   = (longint'(1) << (w - 1)) - 1;
    mn   = -(longint'(1) << (w - 1));
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (sa > mx) sa -= longint'(1) << w;
    if (sb > mx) sb -= longint'(1) << w;
    case (o)
      2'b00:   r = sa + sb;
      2'b10:   r = sa - sb;
      2'b01:   r = sa - sb;
      default: r = sa * sb;
    endcase
    ov = (r > mx) || (r < mn);
    if (o == 2'b01) begin
      dv = r & mask;
      if (dv > mx) dv -= longint'(1) << w;
      if (dv == mn) ov = 1'b1;
      r = (dv < 0) ? -dv : dv;
    end
    return {ov, 32'(r & mask)};
  endfunction

  // Protocol model: index 0 is the WIDTH=4 instance, index 1 the WIDTH=8 instance.
  logic        model_live = 1'b0;
  logic        m_busy[2], m_done[2], m_ov[2], m_zero[2];
  logic [31:0] m_res[2];
  int          m_cnt[2];
  logic [32:0] m_pend[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        st;
      logic [1:0]  o;
      logic [31:0] a, b;
      logic [32:0] r;
      int unsigned w;
      w  = (i == 0) ? 4 : 8;
      st = (i == 0) ? start4 : start8;
      o  = (i == 0) ? op4 : op8;
      a  = (i == 0) ? 32'(a4) : 32'(a8);
      b  = (i == 0) ? 32'(b4) : 32'(b8);
      if (rst) begin
        model_live = 1'b1;
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_res[i] = '0;
        m_ov[i] = 1'b0; m_zero[i] = 1'b0; m_cnt[i] = 0;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_res[i]  = m_pend[i][31:0];
            m_ov[i]   = m_pend[i][32];
            m_zero[i] = (m_pend[i][31:0] == 0);
          end
        end else if (st === 1'b1) begin
          r = model_op(o, a, b, w);
          if (o == 2'b11) begin
            m_busy[i] = 1'b1;
            m_cnt[i]  = int'(w);
            m_pend[i] = r;
          end else begin
            m_done[i] = 1'b1;
            m_res[i]  = r[31:0];
            m_ov[i]   = r[32];
            m_zero[i] = (r[31:0] == 0);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("busy4", 33'(busy4), 33'(m_busy[0]));
      chk("done4", 33'(done4), 33'(m_done[0]));
      chk("res4",  33'(res4),  33'(m_res[0]));
      chk("ovf4",  33'(ov4),   33'(m_ov[0]));
      chk("zero4", 33'(z4),    33'(m_zero[0]));
      chk("busy8", 33'(busy8), 33'(m_busy[1]));
      chk("done8", 33'(done8), 33'(m_done[1]));
      chk("res8",  33'(res8),  33'(m_res[1]));
      chk("ovf8",  33'(ov8),   33'(m_ov[1]));
      chk("zero8", 33'(z8),    33'(m_zero[1]));
    end
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue4(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    start4 = 1'b1; op4 = o; a4 = a; b4 = b;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b; op4 = ~o;
  endtask

  task automatic expect4(input string nm, input logic [3:0] r, input logic ov, input logic z);
    chk({nm, "_res"},  33'(res4),  33'(r));
    chk({nm, "_ovf"},  33'(ov4),   33'(ov));
    chk({nm, "_zero"}, 33'(z4),    33'(z));
    chk({nm, "_done"}, 33'(done4), 33'(1'b1));
  endtask

  task automatic wait_mul4(input string nm, input int exp_cycles);
    int n;
    n = 0;
    while (busy4 === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 33'(n), 33'(exp_cycles));
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; op4 = '0; a8 = '0; b8 = '0; op8 = '0;

    chk("model_add_ovf", model_op(2'b00, 32'h7, 32'h1, 4), {1'b1, 32'h8});
    chk("model_abs_min", model_op(2'b01, 32'h8, 32'h0, 4), {1'b1, 32'h8});
    chk("model_mul_neg", model_op(2'b11, 32'h3, 32'hE, 4), {1'b0, 32'hA});
    chk("model_mul8",    model_op(2'b11, 32'hF6, 32'h0D, 8), {1'b1, 32'h7E});

    repeat (2) @(negedge clk);
    chk("rst_res",  33'(res4),  33'(0));
    chk("rst_busy", 33'(busy4), 33'(0));
    chk("rst_zero", 33'(z4),    33'(0));
    rst = 1'b0;

    issue4(2'b00, 4'b0111, 4'b0001); expect4("add_ovf", 4'b1000, 1'b1, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 33'(done4), 33'(0));
    chk("res_held",       33'(res4),  33'(4'b1000));
    issue4(2'b00, 4'b0011, 4'b1101); expect4("add_zero", 4'b0000, 1'b0, 1'b1);
    issue4(2'b10, 4'b0011, 4'b0011); expect4("sub_zero", 4'b0000, 1'b0, 1'b1);
    issue4(2'b01, 4'b0010, 4'b0101); expect4("abs",      4'b0011, 1'b0, 1'b0);
    issue4(2'b01, 4'b1000, 4'b0000); expect4("abs_min",  4'b1000, 1'b1, 1'b0);

    issue4(2'b11, 4'b0011, 4'b1110); wait_mul4("mul_neg", 4);
    expect4("mul_neg", 4'b1010, 1'b0, 1'b0);
    issue4(2'b11, 4'b0100, 4'b0100); wait_mul4("mul_ovf", 4);
    expect4("mul_ovf", 4'b0000, 1'b1, 1'b1);

    // Adds requested throughout a multiply are ignored; the one held into the done cycle is taken.
    issue4(2'b11, 4'b0010, 4'b0011);
    begin
      int n;
      n = 0;
      while (busy4 === 1'b1 && n < 20) begin
        start4 = 1'b1; op4 = 2'b00; a4 = 4'b0001; b4 = 4'b0001;
        n++;
        @(negedge clk);
      end
      chk("busy_ignore_cycles", 33'(n), 33'(4));
    end
    expect4("mul_ignore", 4'b0110, 1'b0, 1'b0);
    @(negedge clk);
    start4 = 1'b0;
    expect4("add_after_done", 4'b0010, 1'b0, 1'b0);

    issue4(2'b11, 4'b0011, 4'b1110);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 33'(busy4), 33'(0));
    chk("midrst_done", 33'(done4), 33'(0));
    chk("midrst_res",  33'(res4),  33'(0));
    chk("midrst_ovf",  33'(ov4),   33'(0));
    chk("midrst_zero", 33'(z4),    33'(0));
    issue4(2'b00, 4'b0010, 4'b0011); expect4("add_after_rst", 4'b0101, 1'b0, 1'b0);

    for (int c = 0; c < 6000; c++) begin
      start4 = ($urandom_range(3) != 0);
      op4 = 2'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      start8 = ($urandom_range(3) != 0);
      op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
    end
    start4 = 1'b0; start8 = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
